// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the MFA/MFC handshake.
// Holds a byte-addressable, big-endian RAM. Each MFA request performs one
// word or byte access after WAIT_CYCLES wait states and completes on MFC.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (adds MemError; misaligned
// word accesses are trapped instead of silently aligned down).
//
// Handshake: the initiator raises MFA with the request fields valid and
// holds MFA until it sees MFC=1; the request fields are latched on the edge
// that first samples MFA, so later changes are ignored. MFC stays high until
// MFA is sampled low, then drops on that edge. Dropping MFA before MFC
// aborts the request with no memory access.
module mem_responder #(
  parameter int    ADDR_W      = 9,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MFA,
  input  logic              READ_WRITE,
  input  logic              WORD_BYTE,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MFC,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              MemError,
`endif
  output logic [1:0]        o_dbg_state
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]        r_mem [0:DEPTH-1];
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic              r_wb;
  logic [31:0]       r_wdata;
  logic [3:0]        r_cnt;
  logic [31:0]       r_dout;

  logic              w_latch;
  logic              w_dec;
  logic              w_access;
  logic              w_done_exit;
  logic              w_inhibit;
  logic [ADDR_W-1:0] w_a0;
  logic [ADDR_W-1:0] w_a1;
  logic [ADDR_W-1:0] w_a2;
  logic [ADDR_W-1:0] w_a3;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_rd_byte;

  // State register; reset aborts any request in flight.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and per-cycle action strobes.
  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_dec       = 1'b0;
    w_access    = 1'b0;
    w_done_exit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (MFA) begin
          w_latch = 1'b1;
          w_next  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!MFA) begin
          w_next = ST_IDLE;
        end else if (r_cnt != 4'd0) begin
          w_dec = 1'b1;
        end else begin
          w_access = 1'b1;
          w_next   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!MFA) begin
          w_done_exit = 1'b1;
          w_next      = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture and wait-state counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_wb    <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= 4'd0;
    end else if (w_latch) begin
      r_addr  <= Address;
      r_rw    <= READ_WRITE;
      r_wb    <= WORD_BYTE;
      r_wdata <= DataIn;
      r_cnt   <= LP_WAIT;
    end else if (w_dec) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Word accesses ignore the two low address bits; bytes are big-endian.
  assign w_a0      = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_a1      = {r_addr[ADDR_W-1:2], 2'b01};
  assign w_a2      = {r_addr[ADDR_W-1:2], 2'b10};
  assign w_a3      = {r_addr[ADDR_W-1:2], 2'b11};
  assign w_rd_word = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
  assign w_rd_byte = {24'h0, r_mem[r_addr]};

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_err;

  assign w_misalign = r_wb && (r_addr[1:0] != 2'b00);
  assign w_inhibit  = w_misalign;

  // Error flag rises with MFC and clears when MFC clears.
  always_ff @(posedge Clk) begin
    if (Reset)            r_err <= 1'b0;
    else if (w_access)    r_err <= w_misalign;
    else if (w_done_exit) r_err <= 1'b0;
  end

  assign MemError = r_err;
`else
  assign w_inhibit = 1'b0;
`endif

  // Read data register; only reads update it, writes leave it unchanged.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_dout <= '0;
    end else if (w_access && r_rw && !w_inhibit) begin
      r_dout <= r_wb ? w_rd_word : w_rd_byte;
    end
  end

  // RAM write port; contents survive reset, and reset blocks a pending write.
  always_ff @(posedge Clk) begin
    if (!Reset && w_access && !r_rw && !w_inhibit) begin
      if (r_wb) begin
        r_mem[w_a0] <= r_wdata[31:24];
        r_mem[w_a1] <= r_wdata[23:16];
        r_mem[w_a2] <= r_wdata[15:8];
        r_mem[w_a3] <= r_wdata[7:0];
      end else begin
        r_mem[r_addr] <= r_wdata[7:0];
      end
    end
  end

  assign DataOut     = r_dout;
  assign MFC         = (r_state == ST_DONE);
  assign o_dbg_state = r_state;

endmodule
